// File: rtl/ap_ctrl_hs_driver.sv
// Initiator for the HLS ap_ctrl_hs handshake: issues back-to-back transactions and records counts and latency.
// Optional watchdog compiled in with `define AP_CTRL_TIMEOUT_EN.
module ap_ctrl_hs_driver #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned LAT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  output logic             ap_start,
  output logic             ap_continue,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_FINISH    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] remaining;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_inc;
  logic             active;
  logic             accept;
  logic             rem_last;
  logic             wd_hit;

  assign active   = (state == S_START) || (state == S_WAIT_DONE);
  assign accept   = (state == S_IDLE) && cmd_valid;
  assign rem_last = (remaining == CNT_W'(1));
  assign lat_inc  = (lat_cnt == {LAT_W{1'b1}}) ? lat_cnt : lat_cnt + LAT_W'(1);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_nxt = (cmd_count == '0) ? S_FINISH : S_START;
      end
      S_START: begin
        if (wd_hit)        state_nxt = S_FINISH;
        else if (ap_done)  state_nxt = rem_last ? S_FINISH : S_START;
        else if (ap_ready) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (wd_hit)       state_nxt = S_FINISH;
        else if (ap_done) state_nxt = rem_last ? S_FINISH : S_START;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    cmd_ready = 1'b0;
    ap_start  = 1'b0;
    busy      = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE:      cmd_ready = 1'b1;
      S_START:     begin ap_start = 1'b1; busy = 1'b1; end
      S_WAIT_DONE: busy = 1'b1;
      S_FINISH:    finish = 1'b1;
      default:     cmd_ready = 1'b0;
    endcase
  end

  assign ap_continue = 1'b1;

  // Transaction counters and latency; ap_done in START doubles as an implicit ready
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining  <= '0;
      lat_cnt    <= '0;
      issued_cnt <= '0;
      done_cnt   <= '0;
      last_lat   <= '0;
      max_lat    <= '0;
    end else if (accept) begin
      remaining  <= cmd_count;
      lat_cnt    <= LAT_W'(1);
      issued_cnt <= '0;
      done_cnt   <= '0;
      last_lat   <= '0;
      max_lat    <= '0;
    end else if (active) begin
      if ((state == S_START) && (ap_ready || ap_done))
        issued_cnt <= issued_cnt + CNT_W'(1);
      if (ap_done) begin
        done_cnt  <= done_cnt + CNT_W'(1);
        remaining <= remaining - CNT_W'(1);
        last_lat  <= lat_cnt;
        if (lat_cnt > max_lat) max_lat <= lat_cnt;
        lat_cnt   <= LAT_W'(1);
      end else begin
        lat_cnt <= lat_inc;
      end
    end
  end

`ifdef AP_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;

  // Counts cycles since the last handshake event; 1 on the first cycle after a restart
  assign wd_hit = active && !ap_ready && !ap_done && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (accept) begin
      wd_cnt  <= WD_W'(1);
      timeout <= 1'b0;
    end else if (active) begin
      if (ap_ready || ap_done) wd_cnt <= WD_W'(1);
      else if (wd_hit)         timeout <= 1'b1;
      else                     wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 32'd0);
  assign wd_hit             = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule
